// File: rtl/prng_arbiter.sv
// Round-robin arbiter that hands out one pseudo-random byte per grant.
// An 8-bit LFSR supplies the bytes. After reset or a seed load it is stepped
// WARMUP times with all grants held off. After that, each grant takes the
// current LFSR value and advances the LFSR by one step.
module prng_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter logic [7:0]  SEED   = 8'h8A,
  parameter int unsigned WARMUP = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  input  logic            seed_load,
  input  logic [7:0]      seed,
  output logic [NREQ-1:0] gnt,
  output logic [7:0]      rnd_data,
  output logic            warming
);

  localparam int unsigned PtrW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]  WarmCnt  = 8'(WARMUP);
  localparam bit          SkipWarm = (WARMUP == 0);

  typedef enum logic [0:0] {
    StWarm = 1'b0,
    StRun  = 1'b1
  } state_e;

  // A zero WARMUP means the block never enters the warm-up state.
  localparam state_e StInit = SkipWarm ? StRun : StWarm;

  state_e            state_q, state_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [7:0]        rnd_q, rnd_d;

  logic              any_req;
  logic [NREQ-1:0]   win_onehot;
  logic [PtrW-1:0]   ptr_nxt;
  logic [7:0]        lfsr_step;
  logic [7:0]        seed_val;

  // One LFSR step. An all-zero state would lock up, so it falls back to SEED.
  always_comb begin
    if (lfsr_q == 8'h00) begin
      lfsr_step = SEED;
    end else begin
      lfsr_step = {lfsr_q[1] ^ lfsr_q[4] ^ lfsr_q[6] ^ lfsr_q[7], lfsr_q[7:1]};
    end
  end

  // A zero seed would lock up the LFSR, so load SEED in its place.
  always_comb begin
    seed_val = (seed == 8'h00) ? SEED : seed;
  end

  // Round-robin scan: the first asserted request at or above ptr, wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    int unsigned win;
    int unsigned nxt;
    any_req    = 1'b0;
    win_onehot = '0;
    idx        = 0;
    win        = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
    if (any_req) begin
      win_onehot[win] = 1'b1;
    end
    nxt = win + 1;
    if (nxt >= NREQ) begin
      nxt = 0;
    end
    ptr_nxt = nxt[PtrW-1:0];
  end

  // Next-state logic. A seed load takes priority over warm-up and grants.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    rnd_d   = rnd_q;

    if (seed_load) begin
      // The round-robin pointer is left alone so that fairness carries across reseeds.
      lfsr_d  = seed_val;
      cnt_d   = 8'h00;
      state_d = StInit;
    end else begin
      unique case (state_q)
        StWarm: begin
          lfsr_d = lfsr_step;
          cnt_d  = cnt_q + 8'h01;
          if (cnt_d == WarmCnt) begin
            state_d = StRun;
          end
        end
        StRun: begin
          // The LFSR advances only when a grant consumes a byte.
          if (any_req) begin
            gnt_d  = win_onehot;
            rnd_d  = lfsr_q;
            lfsr_d = lfsr_step;
            ptr_d  = ptr_nxt;
          end
        end
        default: begin
          state_d = StInit;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StInit;
      lfsr_q  <= SEED;
      cnt_q   <= 8'h00;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rnd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
    end
  end

  // Registered outputs; warming is decoded from the state register.
  always_comb begin
    gnt      = gnt_q;
    rnd_data = rnd_q;
    warming  = (state_q == StWarm);
  end

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed bench for prng_arbiter. One instance runs with WARMUP=0 and
// another with WARMUP=8. The first is checked against a cycle table. The
// second is checked for warm-up length and the first grant after warm-up.
module tb_prng_arbiter;

  logic       clk;
  logic       reset_n;
  logic       seed_load;
  logic [7:0] seed;
  logic [3:0] req0, req8;
  logic [3:0] gnt0, gnt8;
  logic [7:0] rnd0, rnd8;
  logic       warming0, warming8;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [3:0] req;
    logic       sl;
    logic [7:0] seed;
    logic [3:0] gnt;
    logic [7:0] rnd;
  } vec_t;

  vec_t vecs [0:17];

  prng_arbiter #(.NREQ(4), .SEED(8'h8A), .WARMUP(0)) dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req0),
    .seed_load (seed_load),
    .seed      (seed),
    .gnt       (gnt0),
    .rnd_data  (rnd0),
    .warming   (warming0)
  );

  prng_arbiter #(.NREQ(4), .SEED(8'h8A), .WARMUP(8)) dut8 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req8),
    .seed_load (seed_load),
    .seed      (seed),
    .gnt       (gnt8),
    .rnd_data  (rnd8),
    .warming   (warming8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Count the cycles warming stays high, with a fixed bound on the wait.
  task automatic count_warm(output int cycles);
    cycles = 1;
    while (warming8 === 1'b1 && cycles < 20) begin
      @(posedge clk); #1;
      if (warming8 === 1'b1) cycles++;
      if (gnt8 !== 4'b0000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL warm_gnt: got %b, expected 0000", gnt8);
      end
    end
  endtask

  initial begin
    int wc;
    n_cmp = 0;
    n_bad = 0;
    // Expected values come from stepping the LFSR by hand:
    // 8A -> 45 -> A2 -> 51 -> 28 -> 14 -> 8A ; 01 -> 00 -> 8A ; 5C -> 2E -> 97
    vecs[0]  = '{4'b1111, 1'b0, 8'h00, 4'b0001, 8'h8A};
    vecs[1]  = '{4'b1111, 1'b0, 8'h00, 4'b0010, 8'h45};
    vecs[2]  = '{4'b1111, 1'b0, 8'h00, 4'b0100, 8'hA2};
    vecs[3]  = '{4'b1111, 1'b0, 8'h00, 4'b1000, 8'h51};
    vecs[4]  = '{4'b1111, 1'b0, 8'h00, 4'b0001, 8'h28};
    vecs[5]  = '{4'b0000, 1'b0, 8'h00, 4'b0000, 8'h28};
    vecs[6]  = '{4'b1000, 1'b0, 8'h00, 4'b1000, 8'h14};
    vecs[7]  = '{4'b0110, 1'b0, 8'h00, 4'b0010, 8'h8A};
    vecs[8]  = '{4'b0011, 1'b0, 8'h00, 4'b0001, 8'h45};
    vecs[9]  = '{4'b0000, 1'b1, 8'h01, 4'b0000, 8'h45};
    vecs[10] = '{4'b0001, 1'b0, 8'h00, 4'b0001, 8'h01};
    vecs[11] = '{4'b0001, 1'b0, 8'h00, 4'b0001, 8'h00};
    vecs[12] = '{4'b0001, 1'b0, 8'h00, 4'b0001, 8'h8A};
    vecs[13] = '{4'b0000, 1'b1, 8'h00, 4'b0000, 8'h8A};
    vecs[14] = '{4'b0100, 1'b0, 8'h00, 4'b0100, 8'h8A};
    vecs[15] = '{4'b0001, 1'b1, 8'h5C, 4'b0000, 8'h8A};
    vecs[16] = '{4'b1001, 1'b0, 8'h00, 4'b1000, 8'h5C};
    vecs[17] = '{4'b0011, 1'b0, 8'h00, 4'b0001, 8'h2E};

    reset_n   = 1'b0;
    seed_load = 1'b0;
    seed      = 8'h00;
    req0      = 4'b0000;
    req8      = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt0", {4'b0, gnt0}, 8'h00);
    check("rst_rnd0", rnd0, 8'h00);
    check("rst_warming0", {7'b0, warming0}, 8'h00);
    check("rst_warming8", {7'b0, warming8}, 8'h01);

    @(negedge clk);
    reset_n = 1'b1;

    // Cycle table for the WARMUP=0 instance.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      req0      = vecs[i].req;
      seed_load = vecs[i].sl;
      seed      = vecs[i].seed;
      @(posedge clk); #1;
      check($sformatf("vec%0d_gnt", i), {4'b0, gnt0}, {4'b0, vecs[i].gnt});
      check($sformatf("vec%0d_rnd", i), rnd0, vecs[i].rnd);
    end
    @(negedge clk);
    seed_load = 1'b0;

    // Reset asserted while a grant is high: the grant must drop at once.
    req0 = 4'b0011;
    @(posedge clk); #1;
    check("midrst_pre_gnt", {4'b0, gnt0}, 8'h02);
    check("midrst_pre_rnd", rnd0, 8'h97);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_gnt", {4'b0, gnt0}, 8'h00);
    check("midrst_rnd", rnd0, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("postrst_gnt", {4'b0, gnt0}, 8'h01);
    check("postrst_rnd", rnd0, 8'h8A);
    @(posedge clk); #1;
    check("postrst2_gnt", {4'b0, gnt0}, 8'h02);
    check("postrst2_rnd", rnd0, 8'h45);
    @(negedge clk);
    req0 = 4'b0000;

    // WARMUP=8: warm-up length and the first grant once warm-up is over.
    reset_n = 1'b0;
    req8    = 4'b0100;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    count_warm(wc);
    check("warm_cycles", wc[7:0], 8'd8);
    check("warm_end_gnt", {4'b0, gnt8}, 8'h00);
    @(posedge clk); #1;
    check("warm_first_gnt", {4'b0, gnt8}, 8'h04);
    check("warm_first_rnd", rnd8, 8'hA2);
    @(posedge clk); #1;
    check("warm_second_rnd", rnd8, 8'h51);

    // A seed load during warm-up starts the warm-up count again.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    seed_load = 1'b1;
    seed      = 8'h8A;
    @(posedge clk); #1;
    check("restart_warming", {7'b0, warming8}, 8'h01);
    seed_load = 1'b0;
    seed      = 8'h00;
    count_warm(wc);
    check("restart_cycles", wc[7:0], 8'd8);
    @(posedge clk); #1;
    check("restart_gnt", {4'b0, gnt8}, 8'h04);
    check("restart_rnd", rnd8, 8'hA2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prng_arbiter.md
PRNG_ARBITER -- requirements
Module: prng_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter SEED, default 8'h8A, LFSR reset and recovery value (nonzero).
REQ-003 The block SHALL have parameter WARMUP, default 8, LFSR steps discarded after reset/seed load (0..255).
REQ-004 The block SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port req  input  NREQ  per-requester request, level, held until granted.
REQ-007 The block SHALL have port seed_load  input  1  single-cycle pulse, load seed into LFSR.
REQ-008 The block SHALL have port seed  input  8  seed value, sampled when seed_load=1.
REQ-009 The block SHALL have port gnt  output  NREQ  one-hot grant, registered, one-cycle pulse.
REQ-010 The block SHALL have port rnd_data  output  8  random byte, registered, valid in the gnt cycle, held otherwise.
REQ-011 The block SHALL have port warming  output  1  high while in state WARM.

Function
REQ-012 The LFSR step SHALL be next = {fb, s[7:1]}, fb = s[1]^s[4]^s[6]^s[7}; if s==8'h00, next = SEED (lockup recovery).
REQ-013 The FSM SHALL have two states: WARM and RUN.
REQ-014 In WARM, the LFSR SHALL step every cycle, an 8-bit counter SHALL increment, gnt SHALL be 0, and requests SHALL stay pending.
REQ-015 When the counter reaches WARMUP, WARM SHALL go to RUN on that edge; with WARMUP=0, WARM SHALL be skipped entirely.
REQ-016 In RUN with |req=1 and seed_load=0, on the edge: gnt <= onehot(winner), rnd_data <= current LFSR, LFSR steps once, ptr <= (winner+1) mod NREQ.
REQ-017 In RUN with no request, gnt SHALL be 0 and the LFSR SHALL hold.
REQ-018 Winner SHALL be the first asserted req index scanning upward from ptr, wrapping at NREQ (round-robin).
REQ-019 Grant latency SHALL be one cycle from req sampled high; back-to-back grants SHALL occur every cycle while requests are pending.
REQ-020 A requester SHALL deassert req the cycle after its gnt; if still high, it is treated as a new request.
REQ-021 seed_load SHALL take priority over grants, in any state: LFSR <= (seed==0 ? SEED : seed), counter <= 0, state <= WARM (RUN if WARMUP=0), no gnt that cycle.
REQ-022 seed_load during WARM SHALL restart the warm-up from the new seed.
REQ-023 ptr SHALL be unaffected by seed_load.

Reset
REQ-024 On reset_n=0, asynchronously: LFSR=SEED, counter=0, ptr=0, gnt=0, rnd_data=8'h00, state=WARM (RUN if WARMUP=0), warming=(WARMUP!=0).
REQ-025 Reset mid-grant SHALL clear gnt immediately; pending requests SHALL be re-arbitrated only after reset release and warm-up.

Verification
REQ-026 WARMUP=0, req=4'b1111 held -> gnt 0001,0010,0100,1000,0001 on consecutive cycles; rnd_data 8A,45,A2,51,28.
REQ-027 WARMUP=8, reset release -> warming high for 8 cycles; req=4'b0100 -> gnt=0100, rnd_data=8'hA2.
REQ-028 WARMUP=0, seed_load with seed=8'h01 -> next grants return 01,00,8A (lockup recovery).
REQ-029 WARMUP=0, seed_load with seed=8'h00 -> next grant returns 8A.
REQ-030 WARMUP=0, seed_load and req=4'b0001 in the same cycle -> no gnt that cycle; gnt=0001 with the seed value the next cycle.
REQ-031 WARMUP=0, reset_n pulsed while req=4'b0011 is being granted -> gnt=0 at once; after release: gnt=0001 (ptr=0), rnd_data=8A.
